// File: rtl/tx_buf_pkg.sv
// Shared definitions for the TX buffer writer and the MAC-side reader:
// FSM encoding, header field placement and default buffer geometry.
package tx_buf_pkg;

    localparam int ADDR_W_DEFAULT = 9;
    localparam int BYTE_CNT_LSB   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_HDR    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    function automatic logic [63:0] make_header(input logic [31:0] byte_cnt);
        make_header = {32'h0, byte_cnt} << BYTE_CNT_LSB;
    endfunction

endpackage

// File: rtl/tx_buf_writer_if.sv
// Host-side 64-bit frame stream into the TX buffer writer.
// A beat transfers on a rising edge where s_valid && s_ready; the source holds
// data/keep/last stable while s_valid is high and s_ready is low.
interface tx_buf_writer_if;

    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, s_keep, s_last, s_valid, input s_ready);
    modport slave  (input s_data, s_keep, s_last, s_valid, output s_ready);

endinterface

// File: rtl/tx_buf_writer_keep_popcount.sv
// Byte count of a beat from its keep mask (contiguous from the LSB on the wire).
module keep_popcount (
    input  logic [7:0] keep,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, keep[i]};
        end
    end

endmodule

// File: rtl/tx_buf_writer.sv
// Writes host frames into the TX buffer as header + payload and publishes each
// frame to the reader only once the header is in memory.
module tx_buf_writer
    import tx_buf_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic              clk,
    input  logic              reset,
    tx_buf_writer_if.slave    host,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic [ADDR_W:0]   commited_wr_addr,
    input  logic [ADDR_W:0]   commited_rd_addr,
    output logic              frame_done,
    output logic              frame_drop,
    output state_t            dbg_state
);

    localparam int PW    = ADDR_W + 1;
    localparam int CNT_W = 14;

    localparam logic [PW-1:0]    DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0]    ONE     = PW'(1);
    localparam logic [PW-1:0]    TWO     = PW'(2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME_BYTES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);

    state_t           state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    hdr_addr;
    logic [CNT_W-1:0] byte_cnt;

    logic [PW-1:0]    occ;
    logic [PW-1:0]    free;
    logic [PW-1:0]    ptr_p1;
    logic [3:0]       beat_bytes;
    logic [CNT_W-1:0] cnt_sum;
    logic             ready;
    logic             fire;

    keep_popcount u_keep_popcount (
        .keep  (host.s_keep),
        .count (beat_bytes)
    );

    // occ never exceeds DEPTH, so free cannot underflow.
    always_comb begin
        occ     = wr_ptr - commited_rd_addr;
        free    = DEPTH - occ;
        ptr_p1  = wr_ptr + ONE;
        cnt_sum = byte_cnt + CNT_W'(beat_bytes);
        ready   = 1'b0;
        case (state)
            ST_IDLE: ready = (free >= TWO);
            ST_DATA: ready = (free >= ONE);
            ST_DROP: ready = 1'b1;
            default: ready = 1'b0;
        endcase
        fire = host.s_valid && ready;
    end

    assign host.s_ready = ready;
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            wr_ptr           <= '0;
            hdr_addr         <= '0;
            byte_cnt         <= '0;
            commited_wr_addr <= '0;
            wr_en            <= 1'b0;
            wr_addr          <= '0;
            wr_data          <= '0;
            frame_done       <= 1'b0;
            frame_drop       <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // First beat lands one past the slot reserved for the header.
                    if (fire) begin
                        hdr_addr <= wr_ptr;
                        wr_en    <= 1'b1;
                        wr_addr  <= ptr_p1[ADDR_W-1:0];
                        wr_data  <= host.s_data;
                        wr_ptr   <= wr_ptr + TWO;
                        byte_cnt <= CNT_W'(beat_bytes);
                        state    <= host.s_last ? ST_HDR : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fire) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= wr_ptr[ADDR_W-1:0];
                        wr_data  <= host.s_data;
                        byte_cnt <= cnt_sum;
                        if (cnt_sum > MAX_CNT) begin
                            wr_ptr     <= commited_wr_addr;
                            frame_drop <= 1'b1;
                            state      <= host.s_last ? ST_IDLE : ST_DROP;
                        end else begin
                            wr_ptr <= ptr_p1;
                            if (host.s_last) begin
                                state <= ST_HDR;
                            end
                        end
                    end
                end
                ST_HDR: begin
                    if (byte_cnt < MIN_CNT) begin
                        wr_ptr     <= commited_wr_addr;
                        frame_drop <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= hdr_addr[ADDR_W-1:0];
                        wr_data <= make_header(32'(byte_cnt));
                        state   <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    commited_wr_addr <= wr_ptr;
                    frame_done       <= 1'b1;
                    state            <= ST_IDLE;
                end
                ST_DROP: begin
                    if (fire && host.s_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_buf_writer.sv
// Bench for tx_buf_writer: a frame driver with a reference write model feeding
// an expected-write queue that is drained against the buffer write port.
`timescale 1ns/1ps
module tb_tx_buf_writer;
    import tx_buf_pkg::*;

    localparam int ADDR_W = 9;
    localparam int PW     = ADDR_W + 1;
    localparam int MAXB   = 1518;
    localparam int MINB   = 60;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic [PW-1:0]     commited_wr_addr;
    logic [PW-1:0]     commited_rd_addr;
    logic              frame_done;
    logic              frame_drop;
    state_t            dbg_state;

    tx_buf_writer_if host ();

    tx_buf_writer #(
        .ADDR_W          (ADDR_W),
        .MAX_FRAME_BYTES (MAXB),
        .MIN_FRAME_BYTES (MINB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host             (host),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .commited_wr_addr (commited_wr_addr),
        .commited_rd_addr (commited_rd_addr),
        .frame_done       (frame_done),
        .frame_drop       (frame_drop),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+63:0] exp_q[$];
    logic [PW-1:0]      m_ptr;
    logic [PW-1:0]      m_commit;
    int                 exp_done;
    int                 exp_drop;
    int                 done_cnt;
    int                 drop_cnt;
    int                 drop_beat;
    int                 drop_ready_low;
    bit                 sb_en;
    logic [63:0]        last_wr_data;
    logic [PW-1:0]      saved_commit;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every buffer write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (frame_drop) drop_cnt++;
            if (wr_en) begin
                last_wr_data = wr_data;
                if (sb_en) begin
                    check_val("sb_write_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        logic [ADDR_W+63:0] e;
                        e = exp_q.pop_front();
                        check_val("sb_addr", 64'(wr_addr), 64'(e[ADDR_W+63:64]));
                        check_val("sb_data", wr_data, e[63:0]);
                    end
                end
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int waited;
        host.s_data  = d;
        host.s_keep  = k;
        host.s_last  = l;
        host.s_valid = 1'b1;
        waited = 0;
        while (!host.s_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!host.s_ready) begin
            check_val("ready_timeout", 64'(host.s_ready), 64'd1);
            $display("FAIL ready_timeout: s_ready stuck low, aborting");
            $fatal(1);
        end
        @(posedge clk); #1;
        host.s_valid = 1'b0;
    endtask

    // Holds a beat against a full buffer, then frees 9 slots via the reader.
    task automatic stall_check(input logic [63:0] d, input logic [7:0] k, input logic l);
        host.s_data  = d;
        host.s_keep  = k;
        host.s_last  = l;
        host.s_valid = 1'b1;
        #1;
        check_val("full_ready_low", 64'(host.s_ready), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val("full_ready_held", 64'(host.s_ready), 64'd0);
        commited_rd_addr = 10'd9;
        #1;
        check_val("rd_adv_ready_same_cycle", 64'(host.s_ready), 64'd1);
    endtask

    task automatic send_frame(input int nbytes, input int stall_beat);
        int            nbeats;
        int            nb;
        int            cnt;
        bit            dropped;
        bit            l;
        logic [63:0]   d;
        logic [7:0]    k;
        logic [PW-1:0] hdr;
        logic [PW-1:0] ptr;
        nbeats  = (nbytes + 7) / 8;
        hdr     = m_ptr;
        ptr     = m_ptr + 1'b1;
        cnt     = 0;
        dropped = 0;
        for (int i = 0; i < nbeats; i++) begin
            d  = {$urandom, $urandom};
            l  = (i == nbeats - 1);
            nb = l ? nbytes - 8 * i : 8;
            k  = 8'((9'd1 << nb) - 9'd1);
            if (i == stall_beat) stall_check(d, k, l);
            if (dropped && !host.s_ready) drop_ready_low++;
            drive_beat(d, k, l);
            if (!dropped) begin
                exp_q.push_back({ptr[ADDR_W-1:0], d});
                ptr = ptr + 1'b1;
                cnt += nb;
                if (cnt > MAXB) begin
                    dropped   = 1;
                    drop_beat = i + 1;
                    exp_drop++;
                    check_val("oversize_drop_pulse", 64'(frame_drop), 64'd1);
                end
            end
        end
        host.s_last = 1'b0;
        if (dropped) begin
            m_ptr = m_commit;
        end else if (cnt < MINB) begin
            m_ptr = m_commit;
            exp_drop++;
        end else begin
            exp_q.push_back({hdr[ADDR_W-1:0], 32'(cnt), 32'h0});
            m_ptr    = ptr;
            m_commit = ptr;
            exp_done++;
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val({tag, "_commit"}, 64'(commited_wr_addr), 64'(m_commit));
        check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        check_val({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        host.s_valid     = 1'b0;
        host.s_last      = 1'b0;
        commited_rd_addr = '0;
        m_ptr            = '0;
        m_commit         = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        host.s_data      = '0;
        host.s_keep      = '0;
        host.s_last      = 1'b0;
        host.s_valid     = 1'b0;
        commited_rd_addr = '0;
        exp_done  = 0;
        exp_drop  = 0;
        done_cnt  = 0;
        drop_cnt  = 0;
        drop_beat = 0;
        drop_ready_low = 0;
        sb_en     = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_val("rst_wr_en", 64'(wr_en), 64'd0);
        check_val("rst_commit", 64'(commited_wr_addr), 64'd0);
        check_val("rst_done", 64'(frame_done), 64'd0);
        check_val("rst_drop", 64'(frame_drop), 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        apply_reset();
        check_val("idle_ready", 64'(host.s_ready), 64'd1);

        // 64-byte frame: commit lands on the second edge after the last beat.
        send_frame(64, -1);
        check_val("f64_hdr_state_ready", 64'(host.s_ready), 64'd0);
        @(posedge clk); #1;
        check_val("f64_commit_not_yet", 64'(commited_wr_addr), 64'd0);
        @(posedge clk); #1;
        check_val("f64_commit", 64'(commited_wr_addr), 64'd9);
        check_val("f64_done_pulse", 64'(frame_done), 64'd1);
        settle_and_check("f64");
        commited_rd_addr = m_commit;

        // 61-byte frame: header carries 61 and a 7-qword floor count.
        saved_commit = m_commit;
        send_frame(61, -1);
        settle_and_check("f61");
        check_val("f61_hdr_bytes", 64'(last_wr_data[63:32]), 64'd61);
        check_val("f61_hdr_qwords", 64'(last_wr_data[44:35]), 64'd7);
        check_val("f61_commit_delta", 64'(commited_wr_addr - saved_commit), 64'd9);
        commited_rd_addr = m_commit;

        // Runt, then a good frame reusing the same header slot.
        saved_commit = m_commit;
        send_frame(59, -1);
        settle_and_check("runt");
        check_val("runt_commit_unchanged", 64'(commited_wr_addr), 64'(saved_commit));
        send_frame(64, -1);
        settle_and_check("after_runt");
        commited_rd_addr = m_commit;

        // Oversize frame: dropped on beat 190, remaining beats swallowed.
        saved_commit = m_commit;
        send_frame(1600, -1);
        settle_and_check("oversize");
        check_val("oversize_drop_beat", 64'(drop_beat), 64'd190);
        check_val("oversize_ready_low_beats", 64'(drop_ready_low), 64'd0);
        check_val("oversize_commit_unchanged", 64'(commited_wr_addr), 64'(saved_commit));

        // Fill from an empty buffer with the reader parked at 0.
        apply_reset();
        for (int f = 0; f < 56; f++) send_frame(64, -1);
        send_frame(64, 7);
        settle_and_check("wrap");
        check_val("wrap_commit_value", 64'(commited_wr_addr), 64'h201);
        check_val("wrap_bit", 64'(commited_wr_addr[ADDR_W]), 64'd1);

        // Reset in the middle of a frame.
        sb_en = 1'b0;
        host.s_keep = 8'hFF;
        for (int b = 0; b < 3; b++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        reset = 1'b1;
        #1;
        check_val("midrst_wr_en", 64'(wr_en), 64'd0);
        check_val("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check_val("midrst_wr_data", wr_data, 64'd0);
        check_val("midrst_commit", 64'(commited_wr_addr), 64'd0);
        check_val("midrst_done", 64'(frame_done), 64'd0);
        check_val("midrst_drop", 64'(frame_drop), 64'd0);
        check_val("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        apply_reset();
        sb_en = 1'b1;
        send_frame(64 + 8 * $urandom_range(0, 4), -1);
        settle_and_check("post_reset");

        check_val("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
